// File: rtl/wb_bus_arbiter_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: grant encodings,
// FSM state type, default watchdog sizing and the arbitration rule.
package wb_bus_arbiter_pkg;

    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_M0   = 2'd1;
    localparam logic [1:0] GNT_M1   = 2'd2;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;
    localparam int unsigned DEFAULT_TO_W           = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = GNT_NONE,
        ST_GNT_M0 = GNT_M0,
        ST_GNT_M1 = GNT_M1
    } state_e;

    // Picks the next owner from the current requests; last_m1 is the previous winner.
    function automatic state_e arbitrate(
        input logic cyc0,
        input logic cyc1,
        input logic last_m1,
        input logic round_robin
    );
        if (cyc0 && cyc1) begin
            if (round_robin) begin
                return last_m1 ? ST_GNT_M0 : ST_GNT_M1;
            end
            return ST_GNT_M1;
        end
        if (cyc0) begin
            return ST_GNT_M0;
        end
        if (cyc1) begin
            return ST_GNT_M1;
        end
        return ST_IDLE;
    endfunction

endpackage

// File: rtl/wb_bus_arbiter_watchdog.sv
// Stall watchdog: counts consecutive stalled strobe cycles and raises a
// single-cycle abort when the limit is reached.
module wb_bus_watchdog
    import wb_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int unsigned TO_W           = DEFAULT_TO_W
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic stb_i,
    input  logic ack_i,
    input  logic err_i,
    input  logic clear_i,
    output logic timeout_o
);

    localparam bit              ENABLE     = (TIMEOUT_CYCLES != 0);
    localparam logic [TO_W-1:0] LAST_COUNT = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;
    logic            stalled;

    if (TIMEOUT_CYCLES >= (64'd1 << TO_W)) begin : g_bad_width
        $error("wb_bus_watchdog: TIMEOUT_CYCLES does not fit in TO_W bits");
    end

    // The cycle that would be the TIMEOUT_CYCLES-th stall is the abort cycle.
    always_comb begin
        stalled   = stb_i && !ack_i && !err_i;
        timeout_o = ENABLE && stalled && (cnt_q == LAST_COUNT);
        cnt_d     = '0;
        if (ENABLE && stalled && !clear_i && !timeout_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Two-master Wishbone arbiter: instruction master (m0, read-only) and data
// master (m1) share one slave port; the grant is locked for the whole cyc.
module wb_bus_arbiter
    import wb_bus_arbiter_pkg::*;
#(
    parameter int          ROUND_ROBIN    = 1,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int unsigned TO_W           = DEFAULT_TO_W
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic [31:0] m0_addr_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,

    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,

    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_err_i
);

    localparam logic RR = (ROUND_ROBIN != 0);

    state_e state_q;
    state_e state_d;
    logic   last_m1_q;
    logic   last_m1_d;
    logic   owner_cyc;
    logic   owner_stb;
    logic   timeout;

    always_comb begin
        owner_cyc = 1'b0;
        owner_stb = 1'b0;
        case (state_q)
            ST_GNT_M0: begin
                owner_cyc = m0_cyc_i;
                owner_stb = m0_stb_i;
            end
            ST_GNT_M1: begin
                owner_cyc = m1_cyc_i;
                owner_stb = m1_stb_i;
            end
            default: ;
        endcase
    end

    // Re-arbitrate whenever the bus is free or the owner has just dropped cyc,
    // so a waiting master takes over on the release edge itself.
    always_comb begin
        state_d   = state_q;
        last_m1_d = last_m1_q;
        if (state_q == ST_IDLE || !owner_cyc) begin
            state_d = arbitrate(m0_cyc_i, m1_cyc_i, last_m1_q, RR);
            if (state_d == ST_GNT_M0) begin
                last_m1_d = 1'b0;
            end else if (state_d == ST_GNT_M1) begin
                last_m1_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            last_m1_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            last_m1_q <= last_m1_d;
        end
    end

    wb_bus_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TO_W          (TO_W)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .stb_i    (owner_cyc && owner_stb),
        .ack_i    (s_ack_i),
        .err_i    (s_err_i),
        .clear_i  (state_d != state_q),
        .timeout_o(timeout)
    );

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    // The abort cycle masks cyc/stb to the slave and reports err to the owner.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = 4'h0;
        s_addr_o = 32'h0;
        s_dat_o  = 32'h0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        case (state_q)
            ST_GNT_M0: begin
                s_cyc_o  = m0_cyc_i && !timeout;
                s_stb_o  = m0_stb_i && !timeout;
                s_sel_o  = 4'hF;
                s_addr_o = m0_addr_i;
                m0_ack_o = s_ack_i;
                m0_err_o = s_err_i || timeout;
            end
            ST_GNT_M1: begin
                s_cyc_o  = m1_cyc_i && !timeout;
                s_stb_o  = m1_stb_i && !timeout;
                s_we_o   = m1_we_i;
                s_sel_o  = m1_sel_i;
                s_addr_o = m1_addr_i;
                s_dat_o  = m1_dat_i;
                m1_ack_o = s_ack_i;
                m1_err_o = s_err_i || timeout;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Bench for wb_bus_arbiter: a round-robin and a fixed-priority instance share
// the same stimulus; a grant-level model predicts every output each cycle.
module tb_wb_bus_arbiter;

    localparam int TIMEOUT = 4;
    localparam logic [31:0] A0 = 32'h8000_0000;
    localparam logic [31:0] A1 = 32'h0000_1000;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    logic m0Cyc = 0, m0Stb = 0, m1Cyc = 0, m1Stb = 0;
    logic m1We = 1'b1;
    logic [3:0] m1Sel = 4'h3;
    logic [31:0] m0Addr = A0, m1Addr = A1, m1DatI = 32'h1234_5678;
    logic sAck = 0, sErr = 0;
    logic [31:0] sDatI = 32'h0;

    logic [1:0] sCyc, sStb, sWe, m0Ack, m0Err, m1Ack, m1Err;
    logic [1:0][3:0] sSel;
    logic [1:0][31:0] sAddr, sDatO, m0Dat, m1Dat;

    int nChecks = 0;
    int nPass = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : gDut
        wb_bus_arbiter #(
            .ROUND_ROBIN(k == 0 ? 1 : 0),
            .TIMEOUT_CYCLES(TIMEOUT),
            .TO_W(8)
        ) u (
            .clk_i(clk), .rst_ni(rstN),
            .m0_cyc_i(m0Cyc), .m0_stb_i(m0Stb), .m0_addr_i(m0Addr),
            .m0_dat_o(m0Dat[k]), .m0_ack_o(m0Ack[k]), .m0_err_o(m0Err[k]),
            .m1_cyc_i(m1Cyc), .m1_stb_i(m1Stb), .m1_we_i(m1We), .m1_sel_i(m1Sel),
            .m1_addr_i(m1Addr), .m1_dat_i(m1DatI),
            .m1_dat_o(m1Dat[k]), .m1_ack_o(m1Ack[k]), .m1_err_o(m1Err[k]),
            .s_cyc_o(sCyc[k]), .s_stb_o(sStb[k]), .s_we_o(sWe[k]), .s_sel_o(sSel[k]),
            .s_addr_o(sAddr[k]), .s_dat_o(sDatO[k]), .s_dat_i(sDatI),
            .s_ack_i(sAck), .s_err_i(sErr)
        );
    end

    // Model state per instance: owner is -1 (none), 0 or 1; stall counts
    // consecutive stalled strobe cycles under the current owner.
    int mOwner[2] = '{-1, -1};
    int mLast[2] = '{1, 1};
    int mStall[2] = '{0, 0};
    bit mRr[2] = '{1'b1, 1'b0};

    function automatic int pickWinner(bit c0, bit c1, int last, bit rr);
        if (c0 && c1) return rr ? (1 - last) : 1;
        if (c0) return 0;
        if (c1) return 1;
        return -1;
    endfunction

    function automatic bit ownerStbNow(int k);
        if (mOwner[k] == 0) return m0Cyc && m0Stb;
        if (mOwner[k] == 1) return m1Cyc && m1Stb;
        return 1'b0;
    endfunction

    function automatic bit timeoutNow(int k);
        return ownerStbNow(k) && !sAck && !sErr && (mStall[k] + 1 == TIMEOUT);
    endfunction

    function automatic logic [138:0] expectOutputs(int k);
        logic ec = 0, es = 0, ew = 0, a0 = 0, e0 = 0, a1 = 0, e1 = 0;
        logic [3:0] esel = 0;
        logic [31:0] ea = 0, ed = 0;
        bit to = timeoutNow(k);
        if (mOwner[k] == 0) begin
            ec = m0Cyc && !to; es = m0Stb && !to; esel = 4'hF; ea = m0Addr;
            a0 = sAck; e0 = sErr || to;
        end else if (mOwner[k] == 1) begin
            ec = m1Cyc && !to; es = m1Stb && !to; ew = m1We; esel = m1Sel;
            ea = m1Addr; ed = m1DatI; a1 = sAck; e1 = sErr || to;
        end
        return {ec, es, ew, esel, ea, ed, a0, e0, a1, e1, sDatI, sDatI};
    endfunction

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int k = 0; k < 2; k++) begin
                mOwner[k] = -1; mLast[k] = 1; mStall[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                int nxt;
                bit ownCyc, stalled, to;
                ownCyc = (mOwner[k] == 0) ? m0Cyc : (mOwner[k] == 1) ? m1Cyc : 1'b0;
                stalled = ownerStbNow(k) && !sAck && !sErr;
                to = timeoutNow(k);
                nxt = ownCyc ? mOwner[k] : pickWinner(m0Cyc, m1Cyc, mLast[k], mRr[k]);
                if (nxt != mOwner[k]) mStall[k] = 0;
                else if (stalled && !to) mStall[k] = mStall[k] + 1;
                else mStall[k] = 0;
                if (nxt != mOwner[k] && nxt >= 0) mLast[k] = nxt;
                mOwner[k] = nxt;
            end
        end
    end

    always @(negedge clk) begin
        #1;
        for (int k = 0; k < 2; k++) begin
            logic [138:0] got, exp;
            got = {sCyc[k], sStb[k], sWe[k], sSel[k], sAddr[k], sDatO[k],
                   m0Ack[k], m0Err[k], m1Ack[k], m1Err[k], m0Dat[k], m1Dat[k]};
            exp = expectOutputs(k);
            nChecks++;
            if (got === exp) nPass++;
            else $display("[TB] FAIL model_cmp dut%0d t=%0t: got %h want %h", k, $time, got, exp);
        end
    end

    task automatic applyStimulus(input bit c0, input bit s0, input bit c1, input bit s1,
                                 input bit ack, input bit err, input logic [31:0] dat);
        @(negedge clk);
        m0Cyc = c0; m0Stb = s0; m1Cyc = c1; m1Stb = s1;
        sAck = ack; sErr = err; sDatI = dat;
        #2;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
        applyStimulus(0, 0, 0, 0, 1, 0, 32'h0);
        checkOutput("reset_scyc", 32'(sCyc), 32'h0);
        checkOutput("reset_ack", 32'({m0Ack, m1Ack}), 32'h0);
        @(negedge clk);
        rstN = 1'b1;

        // Single master read from m0.
        applyStimulus(1, 1, 0, 0, 0, 0, 32'h0);
        checkOutput("read_scyc_c0", 32'(sCyc), 32'h0);
        applyStimulus(1, 1, 0, 0, 0, 0, 32'h0);
        checkOutput("read_scyc_c1", 32'(sCyc), 32'h3);
        checkOutput("read_addr", sAddr[0], A0);
        checkOutput("read_sel", 32'(sSel[0]), 32'hF);
        applyStimulus(1, 1, 0, 0, 1, 0, 32'hDEAD_BEEF);
        checkOutput("read_ack", 32'(m0Ack), 32'h3);
        checkOutput("read_dat", m0Dat[0], 32'hDEAD_BEEF);
        checkOutput("read_m1_ack", 32'(m1Ack), 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
        checkOutput("read_release", 32'(sCyc), 32'h0);
        applyStimulus(0, 0, 0, 0, 1, 0, 32'hCAFE_0000);
        checkOutput("idle_ack_ignored", 32'({m0Ack, m1Ack}), 32'h0);

        // Asynchronous reset while m1 owns the bus.
        applyStimulus(0, 0, 1, 1, 0, 0, 32'h0);
        applyStimulus(0, 0, 1, 1, 0, 0, 32'h0);
        checkOutput("rst_pre_stb", 32'(sStb), 32'h3);
        checkOutput("rst_pre_we", 32'(sWe), 32'h3);
        #1 rstN = 1'b0;
        #1 checkOutput("rst_async_cyc", 32'({sCyc, sStb}), 32'h0);
        m1Cyc = 0; m1Stb = 0;
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
        checkOutput("rst_after_idle", 32'(sCyc), 32'h0);

        // Contention, round-robin view on instance 0.
        applyStimulus(1, 1, 1, 1, 0, 0, 32'h0);
        checkOutput("rr_b0_idle", 32'(sCyc), 32'h0);
        applyStimulus(1, 1, 1, 1, 1, 0, 32'h1111_0001);
        checkOutput("rr_g1_addr", sAddr[0], A0);
        checkOutput("rr_g1_m0ack", 32'(m0Ack[0]), 32'h1);
        checkOutput("fp_g1_addr", sAddr[1], A1);
        checkOutput("rr_model_owner", 32'(mOwner[0]), 32'h0);
        applyStimulus(0, 0, 1, 1, 0, 0, 32'h0);
        checkOutput("rr_b2_cyc", 32'(sCyc[0]), 32'h0);
        applyStimulus(1, 1, 1, 1, 1, 0, 32'h1111_0002);
        checkOutput("rr_g2_addr", sAddr[0], A1);
        checkOutput("rr_g2_m1ack", 32'(m1Ack[0]), 32'h1);
        applyStimulus(1, 1, 0, 0, 0, 0, 32'h0);
        applyStimulus(1, 1, 1, 1, 1, 0, 32'h1111_0003);
        checkOutput("rr_g3_addr", sAddr[0], A0);
        applyStimulus(0, 0, 1, 1, 0, 0, 32'h0);
        applyStimulus(1, 1, 1, 1, 1, 0, 32'h1111_0004);
        checkOutput("rr_g4_addr", sAddr[0], A1);
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);

        // Contention, fixed-priority view on instance 1.
        applyStimulus(1, 1, 1, 1, 0, 0, 32'h0);
        applyStimulus(1, 1, 1, 1, 1, 0, 32'h2222_0001);
        checkOutput("fp_c1_addr", sAddr[1], A1);
        checkOutput("fp_c1_ack", 32'({m0Ack[1], m1Ack[1]}), 32'h1);
        checkOutput("rr_c1_addr", sAddr[0], A0);
        applyStimulus(1, 1, 0, 0, 0, 0, 32'h0);
        applyStimulus(1, 1, 1, 1, 1, 0, 32'h2222_0002);
        checkOutput("fp_c3_addr", sAddr[1], A0);
        applyStimulus(0, 0, 1, 1, 0, 0, 32'h0);
        applyStimulus(1, 1, 1, 1, 1, 0, 32'h2222_0003);
        checkOutput("fp_c5_addr", sAddr[1], A1);
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
        applyStimulus(1, 1, 1, 1, 0, 0, 32'h0);
        applyStimulus(1, 1, 1, 1, 1, 0, 32'h2222_0004);
        checkOutput("fp_c8_addr", sAddr[1], A1);
        checkOutput("rr_c8_addr", sAddr[0], A0);
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);

        // Lock: m1 keeps cyc with stb low while m0 waits.
        applyStimulus(0, 0, 1, 1, 0, 0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 1, 1, 0, 0, 0, 32'h0);
            checkOutput($sformatf("lock_addr_%0d", i), sAddr[0], A1);
        end
        checkOutput("lock_cyc_stb", 32'({sCyc[0], sStb[0]}), 32'h2);
        applyStimulus(1, 1, 0, 0, 0, 0, 32'h0);
        checkOutput("lock_release", 32'(sCyc[0]), 32'h0);
        applyStimulus(1, 1, 0, 0, 1, 1, 32'h3333_0001);
        checkOutput("lock_m0_addr", sAddr[0], A0);
        checkOutput("ack_err_both", 32'({m0Ack[0], m0Err[0]}), 32'h3);
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);

        // Watchdog: four stalled cycles abort, then an ack on the fourth wins.
        applyStimulus(1, 1, 0, 0, 0, 0, 32'h0);
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1, 1, 0, 0, 0, 0, 32'h0);
            checkOutput($sformatf("wd_stall_%0d", i), 32'({m0Err, sCyc}), 32'h3);
        end
        applyStimulus(1, 1, 0, 0, 0, 0, 32'h0);
        checkOutput("wd_abort_err", 32'(m0Err), 32'h3);
        checkOutput("wd_abort_cyc", 32'({sCyc, sStb}), 32'h0);
        applyStimulus(1, 1, 0, 0, 0, 0, 32'h0);
        checkOutput("wd_after_abort", 32'({m0Err, sCyc}), 32'h3);
        applyStimulus(1, 1, 0, 0, 0, 0, 32'h0);
        applyStimulus(1, 1, 0, 0, 0, 0, 32'h0);
        applyStimulus(1, 1, 0, 0, 1, 0, 32'h4444_0001);
        checkOutput("wd_ack_wins", 32'({m0Ack, m0Err}), 32'hC);
        checkOutput("wd_ack_cyc", 32'(sCyc), 32'h3);
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);

        @(negedge clk);
        #5;
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/wb_bus_arbiter.md
Name: wb_bus_arbiter

Overview:
- Shares one Wishbone slave bus between the core's instruction master (iwbm, read-only) and data master (dwbm).
- Sits between the core and the single memory/interconnect port, so a single-ported memory can serve both pipeline fetch and load/store.
- Holds a grant for the whole cyc period and supports round-robin or fixed data-priority arbitration.
- Includes a watchdog that aborts hung transfers with err.

Parameters:
ROUND_ROBIN, 1, 1 = alternate on contention; 0 = data master (m1) always wins contention
TIMEOUT_CYCLES, 255, cycles with stb high and no ack/err before abort; 0 disables the watchdog
TO_W, 8, watchdog counter width; must satisfy TIMEOUT_CYCLES < 2^TO_W

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
m0_cyc_i  in  1  instruction master cyc
m0_stb_i  in  1  instruction master stb
m0_addr_i  in  32  instruction address
m0_dat_o  out  32  read data to instruction master
m0_ack_o  out  1  ack to instruction master
m0_err_o  out  1  err to instruction master
m1_cyc_i  in  1  data master cyc
m1_stb_i  in  1  data master stb
m1_we_i  in  1  data write enable
m1_sel_i  in  4  byte selects
m1_addr_i  in  32  data address
m1_dat_i  in  32  write data
m1_dat_o  out  32  read data to data master
m1_ack_o  out  1  ack to data master
m1_err_o  out  1  err to data master
s_cyc_o  out  1  slave cyc
s_stb_o  out  1  slave stb
s_we_o  out  1  slave we
s_sel_o  out  4  slave byte selects
s_addr_o  out  32  slave address
s_dat_o  out  32  slave write data
s_dat_i  in  32  slave read data
s_ack_i  in  1  slave ack
s_err_i  in  1  slave err

Behaviour:
- Reset:
  - rst_ni low forces state IDLE, last_grant=M1 and watchdog=0 immediately, without waiting for a clock edge.
  - All s_* outputs and all m*_ack_o/m*_err_o go to 0 immediately.
  - m*_dat_o carry s_dat_i at all times.
- FSM states: IDLE, GNT_M0, GNT_M1.
- Arbitration is evaluated in IDLE and on any release edge:
  - Single requester (cyc_i high): that requester wins.
  - Both requesting with ROUND_ROBIN=1: the master that is not last_grant wins.
  - Both requesting with ROUND_ROBIN=0: M1 wins.
  - No requester: go to IDLE.
  - The winner is registered at the edge, and last_grant is updated.
- Latency: a request first seen in cycle N drives s_cyc_o/s_stb_o from cycle N+1. A master's cyc must not depend on ack, which the core satisfies.
- Lock: the grant is held while the owner's cyc_i is high, including cycles where the owner's stb_i is low.
- Release and handover:
  - The grant is released at the first edge where the owner's cyc_i is low.
  - Arbitration is re-run at that same edge, so handover to a waiting master has zero dead cycles.
- Muxing (combinational from state):
  - s_cyc_o/s_stb_o/s_we_o/s_sel_o/s_addr_o/s_dat_o follow the owner.
  - For an M0 grant: s_we_o=0, s_sel_o=4'hF, s_dat_o=0.
  - In IDLE, all s_* outputs are 0.
  - Only the owner sees ack/err, which are passed through combinationally from s_ack_i/s_err_i.
- Non-owner: ack_o/err_o are held 0. Its stb is ignored and it waits.
- Watchdog:
  - Increments each cycle the owner's stb is high while s_ack_i and s_err_i are low.
  - Clears on ack, err, owner stb low, or a grant change.
  - When the count reaches TIMEOUT_CYCLES, for one cycle: owner err_o=1, s_cyc_o=0, s_stb_o=0; the counter clears.
  - The grant is retained until the owner drops cyc.
- Simultaneous events:
  - s_ack_i and the timeout in the same cycle: ack wins and no err is issued.
  - s_ack_i and s_err_i both high: both are forwarded unchanged.
- A slave ack arriving in IDLE is ignored.

Decomposition:
- Shared package: grant encodings (GNT_NONE=2'd0, GNT_M0=2'd1, GNT_M1=2'd2) and the default TIMEOUT_CYCLES/TO_W constants.
- One natural sub-module: wb_bus_watchdog, holding the counter, compare and abort pulse. Its interface is stb, ack, err, clear and timeout_o.

Test Plan:
- Reset mid-transfer:
  - Stimulus: M1 owns, s_stb_o=1; assert rst_ni=0 between clock edges.
  - Response: s_cyc_o=0 in the same delta; after release, state IDLE.
- Single master read:
  - Stimulus: m0 requests addr 0x8000_0000 at cycle 0; slave acks at cycle 2 with 0xDEADBEEF.
  - Response: s_cyc_o=1 from cycle 1, s_addr_o=0x8000_0000, m0_ack_o=1 and m0_dat_o=0xDEADBEEF at cycle 2, m1_ack_o=0.
- Contention with ROUND_ROBIN=1:
  - Stimulus: both masters hold cyc; each transfer is acked after 1 cycle and its master then drops cyc for one cycle.
  - Response: grant order M0, M1, M0, M1, with no IDLE cycle between handovers.
- Contention with ROUND_ROBIN=0:
  - Stimulus: same as above.
  - Response: M1 granted first and on every re-arbitration while it requests.
- Lock:
  - Stimulus: M1 owns with cyc=1, stb=0 for 5 cycles while m0 requests.
  - Response: m0 gets no grant until m1_cyc_i falls, then is granted at that edge.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=4; M0 stb high, slave never acks.
  - Response: m0_err_o=1 and s_cyc_o=0 in the 4th stalled cycle, for exactly one cycle.
  - Variant: an ack in that same cycle gives ack only, no err.
